// File: rtl/rf_pkg.sv
// Shared register-file definitions: array geometry and the write-select classifier
// used by both the register file and the upstream decoder bench.
package rf_pkg;

    localparam int NUM_REGS   = 8;
    localparam int REG_ADDR_W = 3;

    typedef enum logic [1:0] {
        SEL_ZERO   = 2'd0,
        SEL_ONEHOT = 2'd1,
        SEL_MULTI  = 2'd2
    } sel_class_t;

    // Clearing the lowest set bit leaves zero exactly when at most one bit was set.
    function automatic sel_class_t onehot_class(input logic [NUM_REGS-1:0] sel);
        logic [NUM_REGS-1:0] low_cleared;
        low_cleared = sel & (sel - {{(NUM_REGS-1){1'b0}}, 1'b1});
        if (sel == '0)
            return SEL_ZERO;
        else if (low_cleared == '0)
            return SEL_ONEHOT;
        else
            return SEL_MULTI;
    endfunction

endpackage

// File: rtl/reg_file_onehot_wr_onehot_check.sv
// Combinational classifier for the one-hot write select: zero / one-hot / multi-hot
// plus the binary index of the selected register.
module onehot_check
    import rf_pkg::*;
(
    input  logic [NUM_REGS-1:0]   sel,
    output logic                  is_zero,
    output logic                  is_onehot,
    output logic                  is_multi,
    output logic [REG_ADDR_W-1:0] idx
);

    sel_class_t cls;

    always_comb begin
        cls       = onehot_class(sel);
        is_zero   = (cls == SEL_ZERO);
        is_onehot = (cls == SEL_ONEHOT);
        is_multi  = (cls == SEL_MULTI);
        // Only meaningful when is_onehot; multi-hot vectors never reach a write.
        idx = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel[i])
                idx = REG_ADDR_W'(i);
        end
    end

endmodule

// File: rtl/reg_file_onehot_wr.sv
// 8-entry register file with one-hot write select, two registered read ports with
// write-to-read bypass, sticky illegal-select flag and accepted-write counter.
module reg_file_onehot_wr
    import rf_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter bit R0_ZERO = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REGS-1:0]   wr_sel,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_data_a,
    output logic [DATA_W-1:0]     rd_data_b,
    output logic                  sel_err,
    output logic [7:0]            wr_count
);

    logic [DATA_W-1:0]     regs [NUM_REGS];
    logic                  sel_zero;
    logic                  sel_onehot;
    logic                  sel_multi;
    logic [REG_ADDR_W-1:0] wr_idx;
    logic                  wr_accept;
    logic [DATA_W-1:0]     rd_next_a;
    logic [DATA_W-1:0]     rd_next_b;

    onehot_check u_onehot_check (
        .sel       (wr_sel),
        .is_zero   (sel_zero),
        .is_onehot (sel_onehot),
        .is_multi  (sel_multi),
        .idx       (wr_idx)
    );

    // A write to the hardwired-zero register is treated as if it never happened.
    always_comb begin
        wr_accept = sel_onehot && !(R0_ZERO && (wr_idx == '0));
    end

    always_comb begin
        rd_next_a = regs[rd_addr_a];
        if (wr_accept && (wr_idx == rd_addr_a))
            rd_next_a = wr_data;
        if (R0_ZERO && (rd_addr_a == '0))
            rd_next_a = '0;

        rd_next_b = regs[rd_addr_b];
        if (wr_accept && (wr_idx == rd_addr_b))
            rd_next_b = wr_data;
        if (R0_ZERO && (rd_addr_b == '0))
            rd_next_b = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            rd_data_a <= '0;
            rd_data_b <= '0;
            sel_err   <= 1'b0;
            wr_count  <= 8'd0;
        end else begin
            if (wr_accept) begin
                regs[wr_idx] <= wr_data;
                wr_count     <= wr_count + 8'd1;
            end
            if (sel_multi)
                sel_err <= 1'b1;
            if (rd_en) begin
                rd_data_a <= rd_next_a;
                rd_data_b <= rd_next_b;
            end
        end
    end

endmodule
